// File: rtl/axis_to_ov7670.sv
// axis_to_ov7670: regenerates an OV7670-style byte stream (vsync, href, dout)
// from an RGB565 AXI4-Stream feed, using a free-running raster that never
// waits on the stream. Missing pixels become 0x0000 and set the sticky underrun
// flag. Misplaced tuser/tlast sets the sticky sync_err flag.
// Optional feature: define AXIS_TO_OV7670_TESTPAT_EN to add the test_en input
// and an eight-bar colour generator.
// Handshake: a beat transfers on a rising aclk edge where tvalid and tready are
// both high. tready never depends on tvalid. In IDLE it depends on tuser, so
// beats before the start of a frame are dropped and the tuser beat is held.
module axis_to_ov7670 #(
  parameter int ACTIVE_W  = 640,
  parameter int ACTIVE_H  = 480,
  parameter int HBLANK    = 144,
  parameter int VSYNC_LEN = 3,
  parameter int VBACK     = 17,
  parameter int VFRONT    = 10
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tuser,
  input  logic        s_axis_video_tlast,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  dout,
  output logic        underrun,
  output logic        sync_err,
  input  logic        clr_err,
`ifdef AXIS_TO_OV7670_TESTPAT_EN
  input  logic        test_en,
`endif
  output logic [2:0]  state_dbg
);

  localparam int LINE_T = 2 * ACTIVE_W + HBLANK;
  localparam int BW     = $clog2(LINE_T);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  // Zero-length blanking phases are skipped at elaboration time.
  localparam state_t AFTER_VSYNC  = (VBACK > 0) ? S_VBACK : S_ACTIVE;
  localparam state_t AFTER_IDLE   = (VSYNC_LEN > 0) ? S_VSYNC : AFTER_VSYNC;
  localparam state_t AFTER_ACTIVE = (VFRONT > 0) ? S_VFRONT : S_IDLE;

  state_t          state;
  state_t          state_after;
  logic [BW-1:0]   byte_cnt;
  logic [BW-2:0]   pix;
  logic [15:0]     line_cnt;
  logic [15:0]     line_lim;
  logic [7:0]      pix_lo;
  logic [15:0]     tp_pix;
  logic            tpat;
  logic            start;
  logic            line_end;
  logic            in_active;
  logic            even_slot;
  logic            accept;
  logic            bad_frame;

  assign state_dbg = state;
  assign pix       = byte_cnt[BW-1:1];
  assign line_end  = (byte_cnt == BW'(LINE_T - 1));
  assign in_active = (state == S_ACTIVE) && (byte_cnt < BW'(2 * ACTIVE_W));
  assign even_slot = in_active && !byte_cnt[0];
  assign accept    = (state == S_ACTIVE) && s_axis_video_tvalid && s_axis_video_tready;

  // A beat is misplaced if tuser is not exactly on line 0 pixel 0, or if tlast is not exactly on the last pixel.
  assign bad_frame =
    (s_axis_video_tuser != ((line_cnt == 16'd0) && (pix == '0))) ||
    (s_axis_video_tlast != (pix == (BW-1)'(ACTIVE_W - 1)));

`ifdef AXIS_TO_OV7670_TESTPAT_EN
  logic [2:0] bar;
  assign bar   = 3'(pix / (BW-1)'(ACTIVE_W / 8));
  assign start = (s_axis_video_tvalid && s_axis_video_tuser) || test_en;

  // Colour of the vertical bar under the current pixel.
  always_comb begin
    tp_pix = 16'h0000;
    case (bar)
      3'd0: tp_pix = 16'hFFFF;
      3'd1: tp_pix = 16'hFFE0;
      3'd2: tp_pix = 16'h07FF;
      3'd3: tp_pix = 16'h07E0;
      3'd4: tp_pix = 16'hF81F;
      3'd5: tp_pix = 16'hF800;
      3'd6: tp_pix = 16'h001F;
      default: tp_pix = 16'h0000;
    endcase
  end

  // Latch the frame source when a frame starts.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tpat <= 1'b0;
    end else if (state == S_IDLE && start) begin
      tpat <= test_en;
    end
  end
`else
  assign start  = s_axis_video_tvalid && s_axis_video_tuser;
  assign tpat   = 1'b0;
  assign tp_pix = 16'h0000;
`endif

  // Line limit and successor state of the current raster phase.
  always_comb begin
    line_lim    = 16'd0;
    state_after = AFTER_IDLE;
    case (state)
      S_VSYNC:  begin line_lim = 16'(VSYNC_LEN - 1); state_after = AFTER_VSYNC;  end
      S_VBACK:  begin line_lim = 16'(VBACK - 1);     state_after = S_ACTIVE;     end
      S_ACTIVE: begin line_lim = 16'(ACTIVE_H - 1);  state_after = AFTER_ACTIVE; end
      S_VFRONT: begin line_lim = 16'(VFRONT - 1);    state_after = S_IDLE;       end
      default:  begin line_lim = 16'd0;              state_after = AFTER_IDLE;   end
    endcase
  end

  // tready: in IDLE it drops tuser-less beats. In a streamed frame it is high only on even active bytes.
  always_comb begin
    s_axis_video_tready = 1'b0;
    if (aresetn) begin
      case (state)
        S_IDLE:   s_axis_video_tready = !s_axis_video_tuser;
        S_ACTIVE: s_axis_video_tready = even_slot && !tpat;
        default:  s_axis_video_tready = 1'b0;
      endcase
    end
  end

  // Raster FSM with counters and registered vsync/href/dout.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      line_cnt <= 16'd0;
      vsync    <= 1'b0;
      href     <= 1'b0;
      dout     <= 8'h00;
      pix_lo   <= 8'h00;
    end else begin
      href <= 1'b0;
      dout <= 8'h00;
      if (state == S_IDLE) begin
        byte_cnt <= '0;
        line_cnt <= 16'd0;
        if (start) begin
          state <= AFTER_IDLE;
          vsync <= (AFTER_IDLE == S_VSYNC);
        end
      end else begin
        if (line_end) begin
          byte_cnt <= '0;
          if (line_cnt == line_lim) begin
            line_cnt <= 16'd0;
            state    <= state_after;
            vsync    <= (state_after == S_VSYNC);
          end else begin
            line_cnt <= line_cnt + 16'd1;
          end
        end else begin
          byte_cnt <= byte_cnt + BW'(1);
        end
        if (even_slot) begin
          href <= 1'b1;
          if (tpat) begin
            dout   <= tp_pix[15:8];
            pix_lo <= tp_pix[7:0];
          end else if (s_axis_video_tvalid) begin
            dout   <= s_axis_video_tdata[15:8];
            pix_lo <= s_axis_video_tdata[7:0];
          end else begin
            dout   <= 8'h00;
            pix_lo <= 8'h00;
          end
        end else if (in_active) begin
          href <= 1'b1;
          dout <= pix_lo;
        end
      end
    end
  end

  // Sticky error flags: a set event beats a clear in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      underrun <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (even_slot && !tpat && !s_axis_video_tvalid) underrun <= 1'b1;
      else if (clr_err)                               underrun <= 1'b0;
      if (accept && bad_frame) sync_err <= 1'b1;
      else if (clr_err)        sync_err <= 1'b0;
    end
  end

endmodule
